// File: rtl/fifo_umbral_param.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds, occupancy and sticky error flags.
// Latency: a popped word appears on data_out one cycle after the accepted read, qualified by valid_out.
// Backpressure: a write while full is dropped (overflow) unless a read frees the slot in the same cycle.
module fifo_umbral_param #(
    parameter int DATA_WIDTH    = 6,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     wr_enable,
    input  logic                     rd_enable,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDRESS_WIDTH:0]   umbral_af,
    input  logic [ADDRESS_WIDTH:0]   umbral_ae,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    output logic [ADDRESS_WIDTH:0]   fifo_cnt,
    output logic                     full_fifo,
    output logic                     empty_fifo,
    output logic                     almost_full_fifo,
    output logic                     almost_empty_fifo,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     error_fifo
);

    localparam int                       DEPTH     = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   cnt;
    logic                     wr_acc;
    logic                     rd_acc;

    // Occupancy-derived status; thresholds are live inputs so flags follow them without delay.
    always_comb begin
        full_fifo         = (cnt == DEPTH_CNT);
        empty_fifo        = (cnt == '0);
        fifo_cnt          = cnt;
        almost_full_fifo  = (cnt >= umbral_af) & ~full_fifo;
        almost_empty_fifo = (cnt <= umbral_ae) & ~empty_fifo;
        error_fifo        = overflow | underflow;
    end

    // Accept logic: a read on a full FIFO frees a slot for the same-cycle write; an empty FIFO never falls through.
    always_comb begin
        rd_acc = init & rd_enable & ~empty_fifo;
        wr_acc = init & wr_enable & (~full_fifo | rd_enable);
    end

    // Storage array; contents are don't-care after reset since the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; depth is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (!init) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Registered read port: data_out is zero and valid_out low in any cycle without an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (!init) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (rd_acc) begin
            data_out  <= mem[rd_ptr];
            valid_out <= 1'b1;
        end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end
    end

    // Sticky error flags; only a hard reset or a soft init clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!init) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_enable & full_fifo & ~rd_enable) begin
                overflow <= 1'b1;
            end
            if (rd_enable & empty_fifo) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_umbral_param.sv
// Bench for fifo_umbral_param: directed scenarios plus randomized traffic checked against a queue model.
module tb_fifo_umbral_param;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int VW    = DW + AW + 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          wr_enable;
    logic          rd_enable;
    logic [DW-1:0] data_in;
    logic [AW:0]   umbral_af;
    logic [AW:0]   umbral_ae;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   fifo_cnt;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic          overflow;
    logic          underflow;
    logic          error_fifo;

    fifo_umbral_param #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .init              (init),
        .wr_enable         (wr_enable),
        .rd_enable         (rd_enable),
        .data_in           (data_in),
        .umbral_af         (umbral_af),
        .umbral_ae         (umbral_ae),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .fifo_cnt          (fifo_cnt),
        .full_fifo         (full_fifo),
        .empty_fifo        (empty_fifo),
        .almost_full_fifo  (almost_full_fifo),
        .almost_empty_fifo (almost_empty_fifo),
        .overflow          (overflow),
        .underflow         (underflow),
        .error_fifo        (error_fifo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: FIFO contents as a queue plus the registered read port and sticky flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_vld  = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    wire [VW-1:0] dut_vec = {data_out, valid_out, fifo_cnt, full_fifo, empty_fifo,
                             almost_full_fifo, almost_empty_fifo, overflow, underflow, error_fifo};

    function automatic logic [VW-1:0] exp_vec();
        int   n     = q.size();
        logic full  = (n == DEPTH);
        logic empty = (n == 0);
        logic af    = (n >= int'(umbral_af)) && !full;
        logic ae    = (n <= int'(umbral_ae)) && !empty;
        return {m_dout, m_vld, (AW+1)'(n), full, empty, af, ae, m_ovf, m_unf, m_ovf | m_unf};
    endfunction

    task automatic model_clear();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d);
        int   n     = q.size();
        logic full  = (n == DEPTH);
        logic empty = (n == 0);
        if (!init) begin
            model_clear();
        end else begin
            if (r && !empty) begin
                m_dout = q.pop_front();
                m_vld  = 1'b1;
            end else begin
                m_dout = '0;
                m_vld  = 1'b0;
            end
            if (w && (!full || r)) q.push_back(d);
            if (w && full && !r) m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
        end
    endtask

    // One clock of stimulus; outputs are settled #1 after the edge on return.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr_enable = w;
        rd_enable = r;
        data_in   = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    task automatic soft_init();
        init = 1'b0;
        step(1'b0, 1'b0, '0);
        init = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        umbral_af = 3'd3; umbral_ae = 3'd1;
        #12;
        model_clear();
        checks++;
        if ({empty_fifo, full_fifo, fifo_cnt, valid_out, data_out, error_fifo} !== {1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0})
            $display("FAIL reset_state: empty=%0b full=%0b cnt=%0d vld=%0b dout=%0h err=%0b, required 1 0 0 0 0 0",
                     empty_fifo, full_fifo, fifo_cnt, valid_out, data_out, error_fifo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i));
        checks++;
        if (full_fifo !== 1'b1 || fifo_cnt !== 3'd4)
            $display("FAIL fill_full: full=%0b cnt=%0d, required 1 4", full_fifo, fifo_cnt);
        else passed++;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== DW'(i) || valid_out !== 1'b1)
                $display("FAIL drain_word%0d: dout=%0h vld=%0b, required %0h 1", i, data_out, valid_out, i);
            else passed++;
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (empty_fifo !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'd0)
            $display("FAIL drain_empty: empty=%0b vld=%0b dout=%0h, required 1 0 0", empty_fifo, valid_out, data_out);
        else passed++;
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(6'h30 + i));
        step(1'b1, 1'b1, 6'h2A);
        checks++;
        if (data_out !== 6'h30 || valid_out !== 1'b1 || fifo_cnt !== 3'd4)
            $display("FAIL full_wr_rd: dout=%0h vld=%0b cnt=%0d, required 30 1 4", data_out, valid_out, fifo_cnt);
        else passed++;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 6'h2A || overflow !== 1'b0 || empty_fifo !== 1'b1)
            $display("FAIL full_wr_rd_last: dout=%0h ovf=%0b empty=%0b, required 2a 0 1", data_out, overflow, empty_fifo);
        else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(6'h08 + i));
        step(1'b1, 1'b0, 6'h15);
        checks++;
        if (overflow !== 1'b1 || error_fifo !== 1'b1 || fifo_cnt !== 3'd4)
            $display("FAIL overflow_set: ovf=%0b err=%0b cnt=%0d, required 1 1 4", overflow, error_fifo, fifo_cnt);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== DW'(6'h08 + i))
                $display("FAIL overflow_dropped%0d: dout=%0h, required %0h", i, data_out, 6'h08 + i);
            else passed++;
        end
        soft_init();
        checks++;
        if (overflow !== 1'b0 || fifo_cnt !== 3'd0 || error_fifo !== 1'b0)
            $display("FAIL init_clear: ovf=%0b cnt=%0d err=%0b, required 0 0 0", overflow, fifo_cnt, error_fifo);
        else passed++;
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, '0);
        checks++;
        if (underflow !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'd0 || fifo_cnt !== 3'd0)
            $display("FAIL underflow_set: unf=%0b vld=%0b dout=%0h cnt=%0d, required 1 0 0 0",
                     underflow, valid_out, data_out, fifo_cnt);
        else passed++;
        step(1'b1, 1'b1, 6'h07);
        checks++;
        if (fifo_cnt !== 3'd1 || underflow !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL empty_wr_rd: cnt=%0d unf=%0b vld=%0b, required 1 1 0", fifo_cnt, underflow, valid_out);
        else passed++;
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 6'h07 || valid_out !== 1'b1)
            $display("FAIL empty_wr_rd_read: dout=%0h vld=%0b, required 07 1", data_out, valid_out);
        else passed++;
        soft_init();
    endtask

    task automatic test_thresholds();
        logic [1:0] exp_flags [5];
        exp_flags[0] = 2'b00; exp_flags[1] = 2'b01; exp_flags[2] = 2'b00;
        exp_flags[3] = 2'b10; exp_flags[4] = 2'b00;
        umbral_af = 3'd3; umbral_ae = 3'd1;
        for (int n = 0; n <= 4; n++) begin
            if (n > 0) step(1'b1, 1'b0, DW'(n));
            checks++;
            if ({almost_full_fifo, almost_empty_fifo} !== exp_flags[n] || fifo_cnt !== (AW+1)'(n))
                $display("FAIL thresh_cnt%0d: af=%0b ae=%0b cnt=%0d, required %0b %0d",
                         n, almost_full_fifo, almost_empty_fifo, fifo_cnt, exp_flags[n], n);
            else passed++;
        end
        checks++;
        if (full_fifo !== 1'b1) $display("FAIL thresh_full: full=%0b, required 1", full_fifo);
        else passed++;
        step(1'b0, 1'b1, '0);
        umbral_af = 3'd0; umbral_ae = 3'd4;
        #1;
        checks++;
        if (almost_full_fifo !== 1'b1 || almost_empty_fifo !== 1'b1)
            $display("FAIL thresh_extremes: af=%0b ae=%0b, required 1 1", almost_full_fifo, almost_empty_fifo);
        else passed++;
        umbral_af = 3'd3; umbral_ae = 3'd1;
        soft_init();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(6'h21 + i));
        step(1'b0, 1'b1, '0);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (empty_fifo !== 1'b1 || fifo_cnt !== 3'd0 || data_out !== 6'd0 || valid_out !== 1'b0)
            $display("FAIL async_reset: empty=%0b cnt=%0d dout=%0h vld=%0b, required 1 0 0 0",
                     empty_fifo, fifo_cnt, data_out, valid_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, DW'(6'h11 + i));
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== DW'(6'h11 + i) || valid_out !== 1'b1)
                $display("FAIL post_reset_read%0d: dout=%0h vld=%0b, required %0h 1", i, data_out, valid_out, 6'h11 + i);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic w, r;
        logic [DW-1:0] d;
        for (int c = 0; c < 400; c++) begin
            umbral_af = (AW+1)'($urandom_range(0, 7));
            umbral_ae = (AW+1)'($urandom_range(0, 7));
            init      = ($urandom_range(0, 29) != 0);
            w         = ($urandom_range(0, 99) < 55);
            r         = ($urandom_range(0, 99) < 45);
            d         = DW'($urandom);
            step(w, r, d);
            init = 1'b1;
            checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_cycle%0d: dout,vld,cnt,full,empty,af,ae,ovf,unf,err=%b, required %b",
                         c, dut_vec, exp_vec());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_simultaneous();
        test_overflow();
        test_underflow();
        test_thresholds();
        test_async_reset();
        soft_init();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
